prog_loader: RTL and testbench
==============================

# prog_loader

Program loader for the multicycle CPU's instruction memory. It receives a byte stream over a valid/ready handshake, checks a header word count and a trailing XOR checksum, and assembles big-endian 16-bit instruction words. Each word is written through the instruction ROM's write port at consecutive addresses. The loader holds the CPU in reset while loading and releases it only after a verified image. It is the writer at the other end of the CPU's instruction-fetch path.

## Interface
- ADDR_WIDTH, 5, instruction memory address width (matches the CPU's 5-bit pc)
- BASE_ADDR, 1, address of the first loaded word (the CPU fetches its first instruction at pc = 1)
- MAX_WORDS, 2**ADDR_WIDTH - BASE_ADDR (= 31), largest legal word count
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle pulse; re-arms the loader from DONE or ERROR
- in_valid  input  1  in_data holds a byte
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  one-cycle write strobe to the instruction memory
- mem_addr  output  ADDR_WIDTH  write address
- mem_wdata  output  16  write data, {hi byte, lo byte}
- cpu_rst  output  1  reset to the CPU; high while loading or in error
- done  output  1  image loaded and checksum matched
- error  output  1  bad word count or checksum mismatch

## Operation
- Byte transfer: a byte is accepted on a rising edge where in_valid && in_ready. in_ready is a combinational function of state only; it never depends on in_valid.
- Stream format: count_hi, count_lo, then N word pairs (hi, lo), then chk_hi, chk_lo.
- Checksum: XOR of the N data words; the header word is excluded.
- States: HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO, DONE, ERROR.
- in_ready = 1 in HDR_HI through CHK_LO; in_ready = 0 in DONE and ERROR.
- HDR_HI → HDR_LO on accept; latch the high byte of the count.
- HDR_LO on accept:
  - If count == 0 or count > MAX_WORDS → ERROR.
  - Otherwise → DATA_HI, with remaining = count, next address = BASE_ADDR, running XOR = 0.
- DATA_HI → DATA_LO on accept; latch the high byte.
- DATA_LO on accept:
  - Register mem_addr = next address and mem_wdata = {hi, lo}; pulse mem_we.
  - Running XOR ^= word; address += 1; remaining -= 1.
  - If remaining was 1 → CHK_HI, otherwise → DATA_HI.
- CHK_HI → CHK_LO on accept.
- CHK_LO on accept: received word == running XOR → DONE, otherwise → ERROR.
- DONE: done = 1, cpu_rst = 0.
- ERROR: error = 1, cpu_rst = 1. Words already written stay in memory; the CPU stays held in reset.
- start in DONE or ERROR → HDR_HI. On the same edge: done, error and running XOR clear, and cpu_rst goes back to 1. start is ignored in all other states.
- Address arithmetic is ADDR_WIDTH bits. Wrap cannot occur because the count check bounds it: last address = BASE_ADDR + N - 1 ≤ 2**ADDR_WIDTH - 1.

## Timing
- Reset values:
  - State HDR_HI.
  - in_ready = 1.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_rst = 1, done = 0, error = 0.
  - Internal count, remaining, address and XOR registers = 0.
- An asynchronous rst mid-load aborts immediately to the reset values. It produces no partial write strobe.
- Write latency: for a DATA_LO byte accepted at edge k, mem_we/mem_addr/mem_wdata are valid from edge k to edge k+1. mem_we is high for exactly one cycle. mem_addr/mem_wdata hold their values until the next write.
- Throughput: one byte per cycle when in_valid is held high; each data word takes 2 cycles.
- CHK_LO byte accepted at edge m → state, done/error and cpu_rst all update at edge m. The CPU therefore leaves reset on the cycle after the final byte.
- A bad header count is detected at the count_lo accept edge. ERROR and in_ready = 0 take effect from that edge, and no mem_we occurs.
- start coinciding with in_valid in DONE/ERROR: start takes effect, and no byte is accepted on that edge (in_ready was 0).

## Test plan
- Stream 00 03 12 34 AB CD 0F 0F B6 F6, in_valid held high:
  - writes (1,0x1234), (2,0xABCD), (3,0x0F0F), each mem_we one cycle wide;
  - done = 1 and cpu_rst = 0 at the CHK_LO accept edge.
- Same stream with checksum B6 F7 → three writes occur, then error = 1, done = 0, cpu_rst = 1, in_ready = 0.
- Header 00 00, then header 00 20 (32 > 31) → ERROR at the count_lo edge, no mem_we. Header 00 1F with 31 words → last write at address 31, done = 1.
- In the first scenario, drop in_valid randomly for 0–3 cycles between bytes → identical writes and final state; no byte is accepted while in_valid = 0.
- Assert rst after the 0xABCD write → all outputs return to reset values at once. Reload the 1-word stream 00 01 55 AA 55 AA → write (1,0x55AA), done = 1.
- From DONE, pulse start with in_valid = 1 → state HDR_HI, done = 0, cpu_rst = 1, no byte accepted that edge. Then load 00 01 00 07 00 07 → write (1,0x0007), done = 1.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader for the CPU instruction memory
//
// Receives a framed byte stream (count_hi, count_lo, N x {hi, lo}, chk_hi, chk_lo),
// writes each big-endian 16-bit word to consecutive instruction memory addresses
// starting at BASE_ADDR, and releases the CPU from reset only once the trailing
// XOR checksum over the data words has matched.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse; re-arms the loader from DONE or ERROR
//   in_valid        in_data holds a byte
//   in_data         stream byte
//   in_ready        loader accepts a byte this cycle (function of state only)
//   mem_we          one-cycle instruction memory write strobe
//   mem_addr        write address (held until the next write)
//   mem_wdata       write data {hi, lo} (held until the next write)
//   cpu_rst         CPU reset; high unless a verified image is loaded
//   done            image loaded and checksum matched
//   error           bad word count or checksum mismatch
module prog_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int BASE_ADDR  = 1,
    parameter int MAX_WORDS  = 2**ADDR_WIDTH - BASE_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error
);

    localparam logic [15:0]           MAX_WORDS_W = 16'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR_W = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHK_HI,
        S_CHK_LO,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q,     state_d;
    logic [7:0]            count_hi_q,  count_hi_d;
    logic [7:0]            hi_q,        hi_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [15:0]           xor_q,       xor_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [15:0]           mem_wdata_q, mem_wdata_d;

    logic                  accept;
    logic [15:0]           hdr_word;
    logic [15:0]           word;

    // Ready depends only on state so the upstream can never see a combinational
    // loop through in_valid.
    assign in_ready = (state_q != S_DONE) && (state_q != S_ERROR);
    assign accept   = in_valid && in_ready;

    // The high byte of a pair is already registered when its low byte arrives.
    assign hdr_word = {count_hi_q, in_data};
    assign word     = {hi_q, in_data};

    // Status flags decode straight from state so they change on the same edge
    // as the final byte's accept; the CPU runs from the following cycle.
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign cpu_rst   = (state_q != S_DONE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HDR_HI;
            count_hi_q  <= '0;
            hi_q        <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            xor_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_hi_q  <= count_hi_d;
            hi_q        <= hi_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            xor_q       <= xor_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_hi_d  = count_hi_q;
        hi_d        = hi_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        xor_d       = xor_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_HDR_HI: begin
                if (accept) begin
                    count_hi_d = in_data;
                    state_d    = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (accept) begin
                    // Bounding the count here is what keeps the write address
                    // from ever wrapping past the top of memory.
                    if (hdr_word == 16'd0 || hdr_word > MAX_WORDS_W) begin
                        state_d = S_ERROR;
                    end else begin
                        remaining_d = hdr_word;
                        addr_d      = BASE_ADDR_W;
                        xor_d       = '0;
                        state_d     = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = word;
                    xor_d       = xor_q ^ word;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - 16'd1;
                    state_d     = (remaining_q == 16'd1) ? S_CHK_HI : S_DATA_HI;
                end
            end
            S_CHK_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = S_CHK_LO;
                end
            end
            S_CHK_LO: begin
                if (accept) begin
                    state_d = (word == xor_q) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                // Memory contents are left alone; only the checksum restarts.
                if (start) begin
                    xor_d   = '0;
                    state_d = S_HDR_HI;
                end
            end
            default: begin
                state_d = S_HDR_HI;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    prog_loader #(.ADDR_WIDTH(5), .BASE_ADDR(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [20:0] got_q[$];
    logic [20:0] exp_q[$];
    bit          exp_done;
    bit          exp_err;
    logic [20:0] last_w = '0;
    logic        prev_we = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: records every strobe, checks strobe width and that the
    // address/data hold between writes.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            last_w  = '0;
            prev_we = 1'b0;
        end else begin
            if (mem_we) begin
                check("we_one_cycle", {31'd0, prev_we}, 32'd0);
                got_q.push_back({mem_addr, mem_wdata});
                last_w = {mem_addr, mem_wdata};
            end else begin
                check("wr_hold", {11'd0, mem_addr, mem_wdata}, {11'd0, last_w});
            end
            prev_we = mem_we;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: parse the byte list by the framing rules.
    task automatic model(input logic [7:0] b[$]);
        int          cnt;
        logic [15:0] x;
        logic [15:0] w;
        logic [15:0] chk;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        x        = '0;
        cnt      = {b[0], b[1]};
        if (cnt == 0 || cnt > 31) begin
            exp_err = 1;
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            w = {b[2 + 2*i], b[3 + 2*i]};
            exp_q.push_back({5'(1 + i), w});
            x ^= w;
        end
        chk = {b[2 + 2*cnt], b[3 + 2*cnt]};
        if (chk == x) exp_done = 1;
        else          exp_err  = 1;
    endtask

    task automatic make_stream(input int n, input bit good, output logic [7:0] s[$]);
        logic [15:0] w;
        logic [15:0] x;
        s.delete();
        x = '0;
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            x ^= w;
            s.push_back(w[15:8]);
            s.push_back(w[7:0]);
        end
        if (!good) x ^= 16'(1 << $urandom_range(0, 15));
        s.push_back(x[15:8]);
        s.push_back(x[7:0]);
    endtask

    // Drives bytes on negedges with up to `gap` idle cycles before each; stops
    // once the loader no longer offers ready. Returns 1 time unit after the
    // edge that accepted the last byte.
    task automatic send(input logic [7:0] b[$], input int gap);
        bit stop;
        int n;
        stop = 0;
        foreach (b[i]) begin
            if (!stop) begin
                n = (gap > 0) ? $urandom_range(0, gap) : 0;
                repeat (n) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end
                @(negedge clk);
                if (!in_ready) begin
                    in_valid = 1'b0;
                    stop     = 1;
                end else begin
                    in_valid = 1'b1;
                    in_data  = b[i];
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
        check("start.done",     {31'd0, done},     32'd0);
        check("start.error",    {31'd0, error},    32'd0);
        check("start.cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("start.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        check({tag, ".n_writes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, ".write"}, {11'd0, got_q[i]}, {11'd0, exp_q[i]});
    endtask

    task automatic run_case(input string tag, input logic [7:0] b[$], input int gap);
        if (done || error) pulse_start();
        got_q.delete();
        model(b);
        send(b, gap);
        check({tag, ".done"},     {31'd0, done},     {31'd0, exp_done});
        check({tag, ".error"},    {31'd0, error},    {31'd0, exp_err});
        check({tag, ".cpu_rst"},  {31'd0, cpu_rst},  {31'd0, !exp_done});
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        compare_writes(tag);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [7:0] s[$];
    logic [7:0] partial[$];

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.in_ready",  {31'd0, in_ready}, 32'd1);
        check("reset.mem_we",    {31'd0, mem_we},   32'd0);
        check("reset.mem_addr",  {27'd0, mem_addr}, 32'd0);
        check("reset.mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("reset.cpu_rst",   {31'd0, cpu_rst},  32'd1);
        check("reset.done",      {31'd0, done},     32'd0);
        check("reset.error",     {31'd0, error},    32'd0);

        s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F, 8'hB6, 8'hF6};
        run_case("basic", s, 0);
        s[9] = 8'hF7;
        run_case("badchk", s, 0);
        s = '{8'h00, 8'h00};
        run_case("hdr0", s, 0);
        s = '{8'h00, 8'h20};
        run_case("hdr32", s, 0);

        make_stream(31, 1, s);
        run_case("max31", s, 0);
        check("max31.last_addr",
              (got_q.size() > 0) ? {27'd0, got_q[got_q.size()-1][20:16]} : 32'd0, 32'd31);

        s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F, 8'hB6, 8'hF6};
        repeat (2) run_case("gaps", s, 3);

        // Asynchronous reset mid-load, right after the 0xABCD write.
        pulse_start();
        got_q.delete();
        partial = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send(partial, 0);
        #1;
        check("abort.pre_writes", got_q.size(), 2);
        #1;
        rst = 1'b1;
        #1;
        check("abort.mem_we",    {31'd0, mem_we},    32'd0);
        check("abort.mem_addr",  {27'd0, mem_addr},  32'd0);
        check("abort.mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("abort.in_ready",  {31'd0, in_ready},  32'd1);
        check("abort.cpu_rst",   {31'd0, cpu_rst},   32'd1);
        check("abort.done",      {31'd0, done},      32'd0);
        check("abort.error",     {31'd0, error},     32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        s = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'h55, 8'hAA};
        run_case("after_rst", s, 0);

        // From DONE: start with in_valid high must not consume a byte.
        s = '{8'h00, 8'h01, 8'h00, 8'h07, 8'h00, 8'h07};
        run_case("restart", s, 0);

        repeat (12) begin
            make_stream($urandom_range(1, 31), 1'($urandom_range(0, 1)), s);
            run_case("rand", s, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
